corral_turn_ctrl: RTL

Turn sequencer for the corral game datapath. Sits between the raw player pins and the `game` core. It synchronises and edge-detects the player's enter button, issues exactly one enter/move pulse per press when the core is ready, and waits for the core to finish the turn. It then serialises cowboy position, horse position and status onto a 4-bit display bus with a tag. It also latches the end-of-game result and counts moves.

---
 rtl/corral_turn_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/corral_turn_ctrl.sv
// corral_turn_ctrl: turn sequencer between the player pins and the corral game core.
// It synchronises the enter/move buttons and issues one move strobe per press.
// It then waits for the core and shows cowboy, horse and status on the display bus.
// Optional move limit: define CORRAL_MOVE_LIMIT_EN to end the game after MOVE_LIMIT moves.
module corral_turn_ctrl #(
  parameter int MOVE_LIMIT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_enter,
  input  logic [2:0] btn_move,
  input  logic       game_ready,
  input  logic       game_over,
  input  logic       game_lostwon,
  input  logic [3:0] cowboy_pos,
  input  logic [3:0] horse_pos,
  output logic       game_enter,
  output logic [2:0] game_move,
  output logic [3:0] data,
  output logic [1:0] data_tag,
  output logic       busy,
  output logic       over,
  output logic       won,
  output logic [3:0] move_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SHOW_C = 3'd3,
    SHOW_H = 3'd4,
    SHOW_S = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [1:0] TAG_NONE   = 2'b00;
  localparam logic [1:0] TAG_COWBOY = 2'b01;
  localparam logic [1:0] TAG_HORSE  = 2'b10;
  localparam logic [1:0] TAG_STATUS = 2'b11;

  // Synchroniser and edge-detect flops
  logic       enter_s1_q, enter_s2_q, enter_s3_q;
  logic [2:0] move_s1_q, move_s2_q;
  logic       enter_rise;

  // FSM and registered outputs
  state_t     state_q, state_d;
  logic       wait_first_q, wait_first_d;
  logic       game_enter_q, game_enter_d;
  logic [2:0] game_move_q, game_move_d;
  logic [3:0] data_q, data_d;
  logic [1:0] data_tag_q, data_tag_d;
  logic       busy_q, busy_d;
  logic       over_q, over_d;
  logic       won_q, won_d;
  logic [3:0] move_count_q, move_count_d;
  logic       limit_hit;

`ifdef CORRAL_MOVE_LIMIT_EN
  localparam logic [3:0] LIMIT = 4'(MOVE_LIMIT);
  // The limit only ends the game when the core has not already finished it.
  assign limit_hit = !game_over && (move_count_q >= LIMIT);
`else
  assign limit_hit = 1'b0;
`endif

  assign enter_rise = enter_s2_q && !enter_s3_q;

  // Two-flop synchronisers plus edge-detect flop; enter chain resets high so a held button is not a press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enter_s1_q <= 1'b1;
      enter_s2_q <= 1'b1;
      enter_s3_q <= 1'b1;
      move_s1_q  <= 3'b000;
      move_s2_q  <= 3'b000;
    end else begin
      enter_s1_q <= btn_enter;
      enter_s2_q <= enter_s1_q;
      enter_s3_q <= enter_s2_q;
      move_s1_q  <= btn_move;
      move_s2_q  <= move_s1_q;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    wait_first_d = wait_first_q;
    game_enter_d = 1'b0;
    game_move_d  = 3'b000;
    data_d       = 4'h0;
    data_tag_d   = TAG_NONE;
    over_d       = over_q;
    won_d        = won_q;
    move_count_d = move_count_q;
    case (state_q)
      IDLE: begin
        // Edges while the core is not ready are simply lost.
        if (enter_rise && game_ready) begin
          state_d      = ISSUE;
          game_enter_d = 1'b1;
          game_move_d  = move_s2_q;
          if (move_count_q != 4'hF) begin
            move_count_d = move_count_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        state_d      = WAIT;
        wait_first_d = 1'b1;
      end
      WAIT: begin
        // The core may still show the stale ready in the first cycle after the strobe.
        wait_first_d = 1'b0;
        if (!wait_first_q && game_ready) begin
          state_d    = SHOW_C;
          data_d     = cowboy_pos;
          data_tag_d = TAG_COWBOY;
        end
      end
      SHOW_C: begin
        state_d    = SHOW_H;
        data_d     = horse_pos;
        data_tag_d = TAG_HORSE;
      end
      SHOW_H: begin
        state_d    = SHOW_S;
        data_d     = {1'b0, limit_hit, game_lostwon, game_over};
        data_tag_d = TAG_STATUS;
      end
      SHOW_S: begin
        if (game_over) begin
          state_d = DONE;
          over_d  = 1'b1;
          won_d   = game_lostwon;
        end else if (limit_hit) begin
          state_d = DONE;
          over_d  = 1'b1;
          won_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and output registers; reset clears any in-flight strobe immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_first_q <= 1'b0;
      game_enter_q <= 1'b0;
      game_move_q  <= 3'b000;
      data_q       <= 4'h0;
      data_tag_q   <= TAG_NONE;
      busy_q       <= 1'b0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
      move_count_q <= 4'h0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= wait_first_d;
      game_enter_q <= game_enter_d;
      game_move_q  <= game_move_d;
      data_q       <= data_d;
      data_tag_q   <= data_tag_d;
      busy_q       <= busy_d;
      over_q       <= over_d;
      won_q        <= won_d;
      move_count_q <= move_count_d;
    end
  end

  assign game_enter = game_enter_q;
  assign game_move  = game_move_q;
  assign data       = data_q;
  assign data_tag   = data_tag_q;
  assign busy       = busy_q;
  assign over       = over_q;
  assign won        = won_q;
  assign move_count = move_count_q;

endmodule
